harness_serial_word_loader: RTL
===============================

# harness_serial_word_loader

Serial-to-parallel operand loader for the FPGA test harnesses. It sits directly upstream of an operand input of a device under test, such as the `a`/`b` operands of the dyadic Boolean operator. It collects one test bit per enabled cycle from a harness pin into a WORD_WIDTH-bit word, then presents each completed word through a valid/ready holding register. A framing counter and an overrun flag make lost or misaligned words visible, which a plain shift register cannot do.

## Interface
- `WORD_WIDTH`, default 36: operand width; must be ≥ 2.
- `MSB_FIRST`, default 1: 1 means the first received bit lands in bit WORD_WIDTH-1; 0 means it lands in bit 0.
- `clock`  in  1: single clock for all state.
- `reset`  in  1: synchronous, active-high.
- `serial_in`  in  1: test bit, sampled only when `shift_en`=1.
- `shift_en`  in  1: accept `serial_in` this cycle.
- `word_out`  out  WORD_WIDTH: holding-register contents.
- `word_valid`  out  1: holding register is full.
- `word_ready`  in  1: consumer takes `word_out` this cycle if `word_valid`=1.
- `bit_count`  out  clog2(WORD_WIDTH): bits already received in the current word, 0..WORD_WIDTH-1.
- `overrun`  out  1: sticky; a completed word was dropped.
- `clear_overrun`  in  1: clears `overrun`.

## Operation
- Reset state: shift register=0, `bit_count`=0, `word_out`=0, `word_valid`=0, `overrun`=0. Reset in the middle of a word discards the partial word.
- Shifting:
  - On `shift_en`=1 with MSB_FIRST=1, the shift register shifts left and `serial_in` enters bit 0.
  - With MSB_FIRST=0, it shifts right and `serial_in` enters bit WORD_WIDTH-1.
  - `bit_count` increments on each accepted bit.
  - With `shift_en`=0, nothing changes.
- Completion happens when `shift_en`=1 and `bit_count`=WORD_WIDTH-1. The completed word is the shift register including the new bit. `bit_count` wraps to 0.
- Holding register:
  - It is empty or draining when `word_valid`=0, or when `word_valid`=1 and `word_ready`=1 in the same cycle.
  - Completion while empty or draining: the completed word loads into `word_out` and `word_valid` becomes 1.
  - Completion while full and not draining: the completed word is dropped, `overrun` is set, and `word_out`/`word_valid` are unchanged.
  - A drain without a completion clears `word_valid`. `word_out` keeps its last value.
- Overrun:
  - `clear_overrun` clears the flag.
  - If a set and a clear happen in the same cycle, the set wins.
  - An overrun does not disturb framing: `bit_count` still wraps.
- `word_ready` while `word_valid`=0 has no effect.

## Timing
- All outputs are registered, with no combinational path from input to output.
- Latency: `word_valid` and `word_out` update in the cycle after the accepting edge of the final bit.
- `bit_count` reflects bits accepted up to the previous edge.
- Throughput: one word per WORD_WIDTH enabled cycles. The consumer may hold `word_ready` high permanently.
- Simultaneous completion and drain: the new word replaces the old one with no bubble, and `word_valid` stays 1.

## Structure
- Shared package `harness_pkg`:
  - a `clog2`-based count width function;
  - a `BIT_ORDER_MSB_FIRST`/`BIT_ORDER_LSB_FIRST` constant pair.
- One natural sub-module: `harness_word_holding_register`. It covers the valid/ready holding register plus the overrun logic, and takes `load` and `word_in`.
- Shift register and counter live in the top module.

## Test plan
The bench uses WORD_WIDTH=8. Stream S is the bits 1,0,1,1,0,0,1,0 in arrival order.
1. Reset, then S with `shift_en`=1 every cycle and `word_ready`=1 → the cycle after the 8th bit, `word_out`=8'hB2 and `word_valid`=1 for exactly one cycle; `bit_count` returns to 0.
2. S with `shift_en` deasserted for 3 cycles after bits 2 and 5 → `bit_count` holds through the gaps; `word_out`=8'hB2.
3. `word_ready`=0, send S then 0,1,0,1,1,0,1,0 (8'h5A) → `word_out` stays 8'hB2 and `overrun`=1 the cycle after the 16th bit. Then `word_ready`=1 for one cycle → `word_valid`=0. Then `clear_overrun` → `overrun`=0.
4. Hold 8'hB2 valid and pulse `word_ready` in the same cycle as the 8th bit of 8'h5A → next cycle `word_out`=8'h5A, `word_valid`=1, `overrun`=0.
5. Assert `reset` after 5 bits of S → `bit_count`=0 and `word_valid`=0. A following full S yields 8'hB2.
6. MSB_FIRST=0, send S → `word_out`=8'h4D.

Source files
------------

// File: rtl/harness_pkg.sv
// Shared constants and helpers for the FPGA test-harness blocks.
package harness_pkg;

   localparam int unsigned BIT_ORDER_MSB_FIRST = 1;
   localparam int unsigned BIT_ORDER_LSB_FIRST = 0;

   // Width of a counter holding 0..width-1; never narrower than one bit.
   function automatic int unsigned count_width(input int unsigned width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/harness_word_holding_register.sv
// Valid/ready holding register for completed words, with a sticky overrun flag
// raised when a completed word arrives while the register is full and not draining.
module harness_word_holding_register #(
   parameter int unsigned WORD_WIDTH = 36
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load,
   input  logic [WORD_WIDTH-1:0] word_in,
   input  logic                  word_ready,
   input  logic                  clear_overrun,
   output logic [WORD_WIDTH-1:0] word_out,
   output logic                  word_valid,
   output logic                  overrun
);

   logic [WORD_WIDTH-1:0] word_q, word_d;
   logic                  valid_q, valid_d;
   logic                  overrun_q, overrun_d;
   logic                  drain;
   logic                  accept;

   always_comb begin
      drain     = valid_q & word_ready;
      accept    = ~valid_q | drain;
      word_d    = word_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      if (load && accept) begin
         word_d  = word_in;
         valid_d = 1'b1;
      end else if (drain) begin
         valid_d = 1'b0;
      end
      // A dropped word outranks a simultaneous clear request.
      if (load && !accept) begin
         overrun_d = 1'b1;
      end else if (clear_overrun) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         word_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         word_q    <= word_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign word_out   = word_q;
   assign word_valid = valid_q;
   assign overrun    = overrun_q;

endmodule

// File: rtl/harness_serial_word_loader.sv
// Serial-to-parallel operand loader: shifts in one bit per enabled cycle and hands
// each completed word to a valid/ready holding register.
module harness_serial_word_loader
   import harness_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = 36,
   parameter int unsigned MSB_FIRST  = BIT_ORDER_MSB_FIRST
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic                                 serial_in,
   input  logic                                 shift_en,
   output logic [WORD_WIDTH-1:0]                word_out,
   output logic                                 word_valid,
   input  logic                                 word_ready,
   output logic [count_width(WORD_WIDTH)-1:0]   bit_count,
   output logic                                 overrun,
   input  logic                                 clear_overrun
);

   localparam int unsigned CountWidth = count_width(WORD_WIDTH);
   localparam logic [CountWidth-1:0] LastBit = CountWidth'(WORD_WIDTH - 1);

   logic [WORD_WIDTH-1:0] shift_q, shift_d;
   logic [CountWidth-1:0] count_q, count_d;
   logic                  complete;

   always_comb begin
      shift_d  = shift_q;
      count_d  = count_q;
      complete = 1'b0;
      if (shift_en) begin
         if (MSB_FIRST == BIT_ORDER_MSB_FIRST) begin
            shift_d = {shift_q[WORD_WIDTH-2:0], serial_in};
         end else begin
            shift_d = {serial_in, shift_q[WORD_WIDTH-1:1]};
         end
         complete = (count_q == LastBit);
         count_d  = complete ? '0 : count_q + CountWidth'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         shift_q <= '0;
         count_q <= '0;
      end else begin
         shift_q <= shift_d;
         count_q <= count_d;
      end
   end

   // The completed word includes the bit accepted on this edge, hence shift_d.
   harness_word_holding_register #(
      .WORD_WIDTH(WORD_WIDTH)
   ) u_holding (
      .clock        (clock),
      .reset        (reset),
      .load         (complete),
      .word_in      (shift_d),
      .word_ready   (word_ready),
      .clear_overrun(clear_overrun),
      .word_out     (word_out),
      .word_valid   (word_valid),
      .overrun      (overrun)
   );

   assign bit_count = count_q;

endmodule
